// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the physical-memory arbiter.
package pmem_arb_pkg;

  localparam int LINE_BYTES = 32;
  localparam int LINE_W     = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_LSQ,
    REQ_I,
    REQ_PREF
  } requester_t;

endpackage

// File: rtl/pmem_arb_priority.sv
// Combinational winner select: LSQ > I-cache > prefetcher, except that a
// starved I-cache request jumps ahead of the LSQ.
module pmem_arb_priority
  import pmem_arb_pkg::*;
(
  input  logic       i_lsq_vld,
  input  logic       i_i_vld,
  input  logic       i_pref_vld,
  input  logic       i_starved,
  output requester_t o_winner
);

  // Pick the requester that owns the next memory transaction.
  always_comb begin
    o_winner = REQ_NONE;
    if (i_starved && i_i_vld) begin
      o_winner = REQ_I;
    end else if (i_lsq_vld) begin
      o_winner = REQ_LSQ;
    end else if (i_i_vld) begin
      o_winner = REQ_I;
    end else if (i_pref_vld) begin
      o_winner = REQ_PREF;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single physical-memory line port between the LSQ, the
// I-cache and the next-line prefetcher, one transaction at a time.
module pmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 64,
  parameter int LINE_W       = 256
) (
  input  logic              clk,
  input  logic              rst,
  // LSQ / data cache
  input  logic              lsq_pmem_read_cla,
  input  logic              lsq_pmem_write_cla,
  input  logic [ADDR_W-1:0] lsq_pmem_address_cla,
  input  logic [LINE_W-1:0] lsq_pmem_wdata_256_cla,
  output logic              lsq_pmem_resp_cla,
  output logic [LINE_W-1:0] lsq_pmem_rdata_256_cla,
  // I-cache
  input  logic              i_pmem_read_cla,
  input  logic              i_pmem_write_cla,
  input  logic [ADDR_W-1:0] i_pmem_address_cla,
  input  logic [LINE_W-1:0] i_pmem_wdata_256_cla,
  output logic              i_pmem_resp_cla,
  output logic [LINE_W-1:0] i_pmem_rdata_256_cla,
  // Prefetcher
  input  logic              pref_pmem_read_cla,
  input  logic              pref_pmem_write_cla,
  input  logic [ADDR_W-1:0] pref_pmem_address_cla,
  input  logic [LINE_W-1:0] pref_pmem_wdata_256_cla,
  output logic              pref_pmem_resp_cla,
  output logic [LINE_W-1:0] pref_pmem_rdata_256_cla,
  // Main memory
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata_256,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata_256,
  output logic              arbiter_idle
);

  import pmem_arb_pkg::*;

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  requester_t        r_owner;
  logic [ADDR_W-1:0] r_addr_q;
  logic [CNT_W-1:0]  r_starve_cnt;

  logic              w_lsq_vld;
  logic              w_i_vld;
  logic              w_pref_vld;
  logic              w_starved;
  requester_t        w_winner;
  logic [ADDR_W-1:0] w_win_addr;

  logic              w_serve;
  logic              w_own_rd;
  logic              w_own_wr;
  logic [LINE_W-1:0] w_own_wdata;
  logic              w_resp;

  assign w_lsq_vld  = lsq_pmem_read_cla  | lsq_pmem_write_cla;
  assign w_i_vld    = i_pmem_read_cla    | i_pmem_write_cla;
  assign w_pref_vld = pref_pmem_read_cla | pref_pmem_write_cla;
  assign w_starved  = (r_starve_cnt == LIMIT_C);

  pmem_arb_priority u_priority (
    .i_lsq_vld  (w_lsq_vld),
    .i_i_vld    (w_i_vld),
    .i_pref_vld (w_pref_vld),
    .i_starved  (w_starved),
    .o_winner   (w_winner)
  );

  // Address of whichever requester wins this IDLE cycle.
  always_comb begin
    w_win_addr = '0;
    case (w_winner)
      REQ_LSQ:  w_win_addr = lsq_pmem_address_cla;
      REQ_I:    w_win_addr = i_pmem_address_cla;
      REQ_PREF: w_win_addr = pref_pmem_address_cla;
      default:  w_win_addr = '0;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: grant from IDLE, hold in SERVE until memory answers,
  // then one turnaround cycle so the requester can drop its request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_winner != REQ_NONE) w_next_state = SERVE;
      SERVE:   if (pmem_resp)            w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latch owner and line address at grant; release ownership after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= REQ_NONE;
      r_addr_q <= '0;
    end else if (r_state == IDLE && w_winner != REQ_NONE) begin
      r_owner  <= w_winner;
      r_addr_q <= w_win_addr;
    end else if (r_state == DONE) begin
      r_owner  <= REQ_NONE;
    end
  end

  // Count LSQ grants that overtake a waiting I-cache request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE && w_winner != REQ_NONE) begin
      if (w_winner == REQ_LSQ && w_i_vld) begin
        if (!w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  // Select the owner's live request signals.
  always_comb begin
    w_own_rd    = 1'b0;
    w_own_wr    = 1'b0;
    w_own_wdata = '0;
    case (r_owner)
      REQ_LSQ: begin
        w_own_rd    = lsq_pmem_read_cla;
        w_own_wr    = lsq_pmem_write_cla;
        w_own_wdata = lsq_pmem_wdata_256_cla;
      end
      REQ_I: begin
        w_own_rd    = i_pmem_read_cla;
        w_own_wr    = i_pmem_write_cla;
        w_own_wdata = i_pmem_wdata_256_cla;
      end
      REQ_PREF: begin
        w_own_rd    = pref_pmem_read_cla;
        w_own_wr    = pref_pmem_write_cla;
        w_own_wdata = pref_pmem_wdata_256_cla;
      end
      default: begin
        w_own_rd    = 1'b0;
        w_own_wr    = 1'b0;
        w_own_wdata = '0;
      end
    endcase
  end

  assign w_serve = (r_state == SERVE);
  assign w_resp  = w_serve & pmem_resp;

  // Memory side: write wins if a requester raises both strobes.
  assign pmem_write     = w_serve & w_own_wr;
  assign pmem_read      = w_serve & w_own_rd & ~w_own_wr;
  assign pmem_address   = w_serve ? r_addr_q : '0;
  assign pmem_wdata_256 = w_serve ? w_own_wdata : '0;
  assign arbiter_idle   = (r_state == IDLE);

  // Requester side: completion passes straight through to the owner only.
  assign lsq_pmem_resp_cla       = w_resp & (r_owner == REQ_LSQ);
  assign i_pmem_resp_cla         = w_resp & (r_owner == REQ_I);
  assign pref_pmem_resp_cla      = w_resp & (r_owner == REQ_PREF);
  assign lsq_pmem_rdata_256_cla  = lsq_pmem_resp_cla  ? pmem_rdata_256 : '0;
  assign i_pmem_rdata_256_cla    = i_pmem_resp_cla    ? pmem_rdata_256 : '0;
  assign pref_pmem_rdata_256_cla = pref_pmem_resp_cla ? pmem_rdata_256 : '0;

  // Read and write together from one requester is a protocol violation.
  a_lsq_rw: assert property (@(posedge clk) disable iff (rst)
    !(lsq_pmem_read_cla && lsq_pmem_write_cla))
    else $warning("pmem_arbiter: LSQ raised read and write together, write forwarded");
  a_i_rw: assert property (@(posedge clk) disable iff (rst)
    !(i_pmem_read_cla && i_pmem_write_cla))
    else $warning("pmem_arbiter: I-cache raised read and write together, write forwarded");
  a_pref_rw: assert property (@(posedge clk) disable iff (rst)
    !(pref_pmem_read_cla && pref_pmem_write_cla))
    else $warning("pmem_arbiter: prefetcher raised read and write together, write forwarded");

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: requester agents, a fixed-latency memory, a
// transaction-level model checked every cycle, and directed scenarios.
module tb_pmem_arbiter;

  localparam int AW    = 64;
  localparam int LW    = 256;
  localparam int LIMIT = 4;
  localparam int MLAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Requester inputs: index 0 = LSQ, 1 = I-cache, 2 = prefetcher
  logic          rd [3];
  logic          wr [3];
  logic [AW-1:0] ad [3];
  logic [LW-1:0] wd [3];
  int            left [3];
  logic          got  [3];

  logic          lsq_resp, i_resp, pref_resp;
  logic [LW-1:0] lsq_rdata, i_rdata, pref_rdata;
  logic          pmem_read, pmem_write, pmem_resp, arbiter_idle;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata_256, pmem_rdata_256;
  logic          mem_en;
  int            mcnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] glog [$];
  logic          prev_idle = 1'b1;

  // Transaction-level model
  int            m_phase;   // 0 waiting for a grant, 1 transfer, 2 turnaround
  int            m_owner;
  logic [AW-1:0] m_addr;
  int            m_starve;

  pmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .lsq_pmem_read_cla       (rd[0]),
    .lsq_pmem_write_cla      (wr[0]),
    .lsq_pmem_address_cla    (ad[0]),
    .lsq_pmem_wdata_256_cla  (wd[0]),
    .lsq_pmem_resp_cla       (lsq_resp),
    .lsq_pmem_rdata_256_cla  (lsq_rdata),
    .i_pmem_read_cla         (rd[1]),
    .i_pmem_write_cla        (wr[1]),
    .i_pmem_address_cla      (ad[1]),
    .i_pmem_wdata_256_cla    (wd[1]),
    .i_pmem_resp_cla         (i_resp),
    .i_pmem_rdata_256_cla    (i_rdata),
    .pref_pmem_read_cla      (rd[2]),
    .pref_pmem_write_cla     (wr[2]),
    .pref_pmem_address_cla   (ad[2]),
    .pref_pmem_wdata_256_cla (wd[2]),
    .pref_pmem_resp_cla      (pref_resp),
    .pref_pmem_rdata_256_cla (pref_rdata),
    .pmem_read               (pmem_read),
    .pmem_write              (pmem_write),
    .pmem_address            (pmem_address),
    .pmem_wdata_256          (pmem_wdata_256),
    .pmem_resp               (pmem_resp),
    .pmem_rdata_256          (pmem_rdata_256),
    .arbiter_idle            (arbiter_idle)
  );

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] logat(input int i);
    if (i < glog.size()) return glog[i];
    return '1;
  endfunction

  // Model: who owns the port, at what address, and the starvation count.
  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_phase  <= 0;
      m_owner  <= -1;
      m_addr   <= '0;
      m_starve <= 0;
    end else begin
      case (m_phase)
        0: begin
          w = -1;
          if (m_starve == LIMIT && (rd[1] || wr[1])) w = 1;
          else if (rd[0] || wr[0]) w = 0;
          else if (rd[1] || wr[1]) w = 1;
          else if (rd[2] || wr[2]) w = 2;
          if (w >= 0) begin
            m_owner <= w;
            m_addr  <= ad[w];
            m_phase <= 1;
            if (w == 0 && (rd[1] || wr[1]))
              m_starve <= (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else
              m_starve <= 0;
          end
        end
        1: if (pmem_resp) m_phase <= 2;
        default: begin
          m_phase <= 0;
          m_owner <= -1;
        end
      endcase
    end
  end

  // Every cycle: compare all DUT outputs with the model, log grants.
  always @(negedge clk) begin
    logic          e_rd, e_wr;
    logic [AW-1:0] e_ad;
    logic [LW-1:0] e_wd;
    logic          e_r [3];
    e_rd = 1'b0; e_wr = 1'b0; e_ad = '0; e_wd = '0;
    for (int k = 0; k < 3; k++) e_r[k] = (m_phase == 1) && pmem_resp && (m_owner == k);
    if (m_phase == 1) begin
      e_wr = wr[m_owner];
      e_rd = rd[m_owner] && !wr[m_owner];
      e_ad = m_addr;
      e_wd = wd[m_owner];
    end
    chk("pmem_read",      LW'(pmem_read),    LW'(e_rd));
    chk("pmem_write",     LW'(pmem_write),   LW'(e_wr));
    chk("pmem_address",   LW'(pmem_address), LW'(e_ad));
    chk("pmem_wdata",     pmem_wdata_256,    e_wd);
    chk("arbiter_idle",   LW'(arbiter_idle), LW'(m_phase == 0));
    chk("lsq_resp",       LW'(lsq_resp),     LW'(e_r[0]));
    chk("i_resp",         LW'(i_resp),       LW'(e_r[1]));
    chk("pref_resp",      LW'(pref_resp),    LW'(e_r[2]));
    chk("lsq_rdata",      lsq_rdata,  e_r[0] ? pmem_rdata_256 : '0);
    chk("i_rdata",        i_rdata,    e_r[1] ? pmem_rdata_256 : '0);
    chk("pref_rdata",     pref_rdata, e_r[2] ? pmem_rdata_256 : '0);
    if (prev_idle && !arbiter_idle) glog.push_back(pmem_address);
    prev_idle = arbiter_idle;
    if (lsq_resp)  got[0] = 1'b1;
    if (i_resp)    got[1] = 1'b1;
    if (pref_resp) got[2] = 1'b1;
  end

  // Requester agents: drop a request once its last transaction completes.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (got[k]) begin
        got[k] = 1'b0;
        if (left[k] > 0) left[k]--;
        if (left[k] == 0) begin
          rd[k] = 1'b0;
          wr[k] = 1'b0;
        end
      end
    end
  end

  // Memory: answers a strobe after MLAT cycles with address-derived data.
  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      if (pmem_resp) begin
        pmem_resp      = 1'b0;
        pmem_rdata_256 = '0;
      end else if (pmem_read || pmem_write) begin
        mcnt++;
        if (mcnt >= MLAT) begin
          pmem_resp      = 1'b1;
          pmem_rdata_256 = {32{pmem_address[7:0] ^ 8'hA5}};
          mcnt           = 0;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; wd[k] = '0; left[k] = 0; got[k] = 1'b0;
    end
    pmem_resp = 1'b0; pmem_rdata_256 = '0; mem_en = 1'b1; mcnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    glog.delete();
  endtask

  task automatic req(input int k, input logic r, input logic w, input logic [AW-1:0] a, input int n);
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = {8{a[31:0] ^ 32'h5A5A_0000}}; left[k] = n;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int c;
    logic done;
    c = 0;
    done = 1'b0;
    while (!done && c < maxc) begin
      @(posedge clk); #1;
      c++;
      done = (left[0] == 0) && (left[1] == 0) && (left[2] == 0) && arbiter_idle;
    end
    chk(nm, LW'(done), LW'(1'b1));
  endtask

  initial begin
    logic [LW-1:0] a5;
    logic          seen;
    int            c;
    a5 = {32{8'hA5}};

    // 1: pending LSQ read through reset release
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; wd[k] = '0; left[k] = 0; got[k] = 1'b0;
    end
    pmem_resp = 1'b0; pmem_rdata_256 = '0; mem_en = 1'b1; mcnt = 0;
    @(posedge clk); #1;
    chk("t1_rst_idle",  LW'(arbiter_idle), LW'(1'b1));
    chk("t1_rst_read",  LW'(pmem_read),    LW'(1'b0));
    chk("t1_rst_addr",  LW'(pmem_address), LW'(0));
    req(0, 1'b1, 1'b0, 64'h1000, 1);
    @(negedge clk); rst = 1'b0; #1;
    chk("t1_c1_idle",   LW'(arbiter_idle), LW'(1'b1));
    @(posedge clk); #1;
    chk("t1_c2_read",   LW'(pmem_read),    LW'(1'b1));
    chk("t1_c2_addr",   LW'(pmem_address), LW'(64'h1000));
    seen = 1'b0; c = 0;
    while (!seen && c < 10) begin
      @(negedge clk); c++;
      if (lsq_resp) begin
        seen = 1'b1;
        chk("t1_rdata",    lsq_rdata,      a5);
        chk("t1_pmemresp", LW'(pmem_resp), LW'(1'b1));
      end
    end
    chk("t1_resp_seen", LW'(seen), LW'(1'b1));
    @(posedge clk); #1;
    chk("t1_done_idle", LW'(arbiter_idle), LW'(1'b0));
    chk("t1_done_read", LW'(pmem_read),    LW'(1'b0));
    @(posedge clk); #1;
    chk("t1_back_idle", LW'(arbiter_idle), LW'(1'b1));

    // 2: three simultaneous requests
    do_reset();
    @(posedge clk); #1;
    req(0, 1'b1, 1'b0, 64'h1100, 1);
    req(1, 1'b1, 1'b0, 64'h2100, 1);
    req(2, 1'b1, 1'b0, 64'h3100, 1);
    wait_done("t2_done", 60);
    chk("t2_n",  LW'(glog.size()), LW'(3));
    chk("t2_g0", LW'(logat(0)), LW'(64'h1100));
    chk("t2_g1", LW'(logat(1)), LW'(64'h2100));
    chk("t2_g2", LW'(logat(2)), LW'(64'h3100));

    // 3: I-cache starvation override after four LSQ grants
    do_reset();
    @(posedge clk); #1;
    req(0, 1'b1, 1'b0, 64'h5000, 6);
    req(1, 1'b1, 1'b0, 64'h2000, 1);
    wait_done("t3_done", 120);
    chk("t3_n", LW'(glog.size()), LW'(7));
    for (int i = 0; i < 7; i++)
      chk($sformatf("t3_g%0d", i), LW'(logat(i)), LW'((i == 4) ? 64'h2000 : 64'h5000));

    // 4: asynchronous reset in the middle of an I-cache write
    do_reset();
    mem_en = 1'b0;
    @(posedge clk); #1;
    req(1, 1'b0, 1'b1, 64'h2040, 1);
    @(posedge clk); #1;
    chk("t4_write", LW'(pmem_write),   LW'(1'b1));
    chk("t4_addr",  LW'(pmem_address), LW'(64'h2040));
    #2;
    rst = 1'b1;
    #1;
    chk("t4_rst_write", LW'(pmem_write),     LW'(1'b0));
    chk("t4_rst_idle",  LW'(arbiter_idle),   LW'(1'b1));
    chk("t4_rst_addr",  LW'(pmem_address),   LW'(0));
    chk("t4_rst_wdata", pmem_wdata_256,      '0);
    rd[1] = 1'b0; wr[1] = 1'b0; left[1] = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata_256 = '1;
    @(negedge clk);
    chk("t4_late_i",    LW'(i_resp),   LW'(1'b0));
    chk("t4_late_lsq",  LW'(lsq_resp), LW'(1'b0));
    chk("t4_late_idle", LW'(arbiter_idle), LW'(1'b1));
    @(posedge clk); #1;
    pmem_resp = 1'b0; pmem_rdata_256 = '0;
    mem_en = 1'b1;

    // 5: no preemption of a prefetch by a later LSQ request
    do_reset();
    @(posedge clk); #1;
    req(2, 1'b1, 1'b0, 64'h3020, 1);
    c = 0;
    while (arbiter_idle && c < 10) begin @(posedge clk); #1; c++; end
    chk("t5_granted", LW'(arbiter_idle), LW'(1'b0));
    chk("t5_addr",    LW'(pmem_address), LW'(64'h3020));
    req(0, 1'b1, 1'b0, 64'h1040, 1);
    seen = 1'b0; c = 0;
    while (!seen && c < 10) begin
      @(negedge clk); c++;
      chk("t5_busy", LW'(arbiter_idle), LW'(1'b0));
      chk("t5_lsq_quiet", LW'(lsq_resp), LW'(1'b0));
      seen = pref_resp;
    end
    chk("t5_pref_resp", LW'(seen), LW'(1'b1));
    wait_done("t5_done", 60);
    chk("t5_n",  LW'(glog.size()), LW'(2));
    chk("t5_g0", LW'(logat(0)), LW'(64'h3020));
    chk("t5_g1", LW'(logat(1)), LW'(64'h1040));

    // 6: LSQ raises read and write together
    do_reset();
    @(posedge clk); #1;
    req(0, 1'b1, 1'b1, 64'h4000, 1);
    @(posedge clk); #1;
    chk("t6_write", LW'(pmem_write),   LW'(1'b1));
    chk("t6_read",  LW'(pmem_read),    LW'(1'b0));
    chk("t6_addr",  LW'(pmem_address), LW'(64'h4000));
    wait_done("t6_done", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single 256-bit physical-memory port between three requesters: the LSQ/data cache, the instruction cache and the next-line prefetcher.
- Fixed priority LSQ > I-cache > prefetcher, with an anti-starvation override for the I-cache.
- Drives `arbiter_idle`, which the prefetcher uses to issue only into an otherwise quiet port.
- Sits between the cache-line adapters and main memory; one transaction in flight at a time.

Parameters:
- STARVE_LIMIT, 4: consecutive LSQ grants taken while an I-cache request waits before the I-cache is forced ahead of the LSQ.
- ADDR_W, 64: address width.
- LINE_W, 256: cache-line data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- lsq_pmem_read_cla / lsq_pmem_write_cla  in  1  LSQ line read / write request
- lsq_pmem_address_cla  in  ADDR_W  LSQ line address
- lsq_pmem_wdata_256_cla  in  LINE_W  LSQ write line
- lsq_pmem_resp_cla  out  1  LSQ completion
- lsq_pmem_rdata_256_cla  out  LINE_W  LSQ read line
- i_pmem_read_cla / i_pmem_write_cla / i_pmem_address_cla / i_pmem_wdata_256_cla  in  —  I-cache request; widths as LSQ
- i_pmem_resp_cla / i_pmem_rdata_256_cla  out  —  I-cache response; widths as LSQ
- pref_pmem_read_cla / pref_pmem_write_cla / pref_pmem_address_cla / pref_pmem_wdata_256_cla  in  —  prefetcher request; widths as LSQ
- pref_pmem_resp_cla / pref_pmem_rdata_256_cla  out  —  prefetcher response; widths as LSQ
- pmem_read / pmem_write  out  1  memory read / write strobe
- pmem_address  out  ADDR_W  memory address
- pmem_wdata_256  out  LINE_W  memory write data
- pmem_resp  in  1  memory completion
- pmem_rdata_256  in  LINE_W  memory read data
- arbiter_idle  out  1  high exactly when state == IDLE

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state = IDLE, starve_cnt = 0, addr_q = 0, owner = NONE.
  - All strobes and resps low, data outputs 0, arbiter_idle = 1.
  - An in-flight memory transaction is abandoned; its late pmem_resp is ignored in IDLE.
- States:
  - IDLE: evaluate requests. If any is valid, register the winner's address into addr_q, set owner, go to SERVE. Otherwise stay in IDLE.
  - SERVE:
    - pmem_read/pmem_write = owner's live read/write inputs.
    - pmem_address = addr_q (stable for the whole transaction).
    - pmem_wdata_256 = owner's live wdata.
    - On pmem_resp: owner's resp = 1 combinationally, same cycle; owner's rdata = pmem_rdata_256. Go to DONE.
  - DONE: one turnaround cycle. All strobes low, no grant, lets the requester drop its request. Then IDLE.
- Latency:
  - Grant takes effect 1 cycle after the request is seen in IDLE.
  - Response is same-cycle pass-through.
  - Back-to-back grants are spaced by a minimum of 3 cycles (SERVE, DONE, IDLE).
- Arbitration in IDLE (request valid = read | write):
  - If starve_cnt == STARVE_LIMIT and I-cache valid: grant I-cache.
  - Else: LSQ, then I-cache, then prefetcher.
  - The prefetcher has no starvation protection (speculative).
- starve_cnt:
  - On an LSQ grant with an I-cache request pending: increment, saturating at STARVE_LIMIT.
  - On an I-cache grant, or on any grant with no I-cache request pending: clear to 0.
  - Width is clog2(STARVE_LIMIT+1).
- Non-owners: resp = 0, rdata = 0 at all times.
- Requester asserting read and write together: protocol violation. Write is forwarded; a simulation assertion fires.
- Owner dropping its request in SERVE before pmem_resp: strobes follow to 0; arbiter still waits for pmem_resp.
- pmem_resp in IDLE or DONE: ignored.

Decomposition:
- Shared package `pmem_arb_pkg`:
  - enum `arb_state_t` {IDLE, SERVE, DONE}
  - enum `requester_t` {REQ_NONE, REQ_LSQ, REQ_I, REQ_PREF}
  - constants LINE_BYTES = 32, LINE_W = 256
- One sub-module, `pmem_arb_priority`: combinational winner select from the three valids plus the starve flag, returning a `requester_t`.
- Datapath muxing and the FSM stay in the top level.

Test Plan:
1. Reset with an LSQ read at 0x1000 pending, released.
   - Cycle 1: arbiter_idle = 1.
   - Cycle 2: pmem_read = 1, pmem_address = 0x1000.
   - pmem_resp with rdata = 0xA5 repeated → lsq_pmem_resp_cla and that data in the same cycle, then DONE, then arbiter_idle = 1 the following cycle.
2. LSQ, I-cache and prefetcher all request in the same IDLE cycle → grant order LSQ, then I-cache, then prefetcher. Each pmem_address matches its requester's address.
3. STARVE_LIMIT = 4; LSQ requests continuously while an I-cache read at 0x2000 waits → four LSQ grants, then the I-cache is granted (pmem_address = 0x2000), then starve_cnt = 0.
4. Async rst mid-SERVE on an I-cache write → outputs clear immediately without a clock edge. A later pmem_resp produces no requester resp.
5. Prefetcher read at 0x3020 granted; LSQ read raised during SERVE → no preemption. The prefetch completes, then the LSQ is granted after DONE/IDLE. arbiter_idle stays 0 throughout the prefetch SERVE.
6. LSQ asserts read and write together with address 0x4000 → pmem_write = 1, pmem_read = 0, and the assertion is logged.
